// File: rtl/qq_host_ctrl_if.sv
// Host command/response channel plus queue head-block strobes for qq_host_ctrl.
// slave = controller view, master = host/queue environment view.
interface qq_host_ctrl_if #(
    parameter int unsigned W = 32
) ();
    logic         cmd_valid_i;
    logic         cmd_ready_o;
    logic         cmd_op_i;
    logic [W-1:0] cmd_key_i;
    logic         rsp_valid_o;
    logic         rsp_ready_i;
    logic         rsp_op_o;
    logic [W-1:0] rsp_key_o;
    logic         rsp_err_o;
    logic         q_rdy_i;
    logic         q_enq_o;
    logic         q_deq_o;
    logic [W-1:0] q_data_o;
    logic [W-1:0] q_data_i;

    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_key_i, rsp_ready_i, q_rdy_i, q_data_i,
        output cmd_ready_o, rsp_valid_o, rsp_op_o, rsp_key_o, rsp_err_o,
               q_enq_o, q_deq_o, q_data_o
    );

    modport master (
        output cmd_valid_i, cmd_op_i, cmd_key_i, rsp_ready_i, q_rdy_i, q_data_i,
        input  cmd_ready_o, rsp_valid_o, rsp_op_o, rsp_key_o, rsp_err_o,
               q_enq_o, q_deq_o, q_data_o
    );
endinterface

// File: rtl/qq_host_ctrl.sv
// Host-side controller for a min-priority queue: one outstanding ENQ/DEQ command,
// occupancy tracking, MAX_KEY/full/empty rejection and a sticky ready-timeout fault.
module qq_host_ctrl #(
    parameter int unsigned W   = 32,
    parameter int unsigned CAP = 16,
    parameter int unsigned TO  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    qq_host_ctrl_if.slave              bus,
    output logic [$clog2(CAP+1)-1:0]   count_o,
    output logic                       fault_o
);
    localparam int unsigned CW = $clog2(CAP + 1);
    localparam int unsigned TW = $clog2(TO + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_RESP, S_FAULT
    } state_t;

    state_t         r_state;
    logic           r_op;
    logic [W-1:0]   r_key;
    logic           r_cmd_ready;
    logic           r_rsp_valid;
    logic           r_rsp_op;
    logic [W-1:0]   r_rsp_key;
    logic           r_rsp_err;
    logic [CW-1:0]  r_count;
    logic           r_fault;
    logic [TW-1:0]  r_tmo;
    logic           r_wait_first;

    logic           w_issue_go;
    logic           w_reject;
    logic           w_tmo_hit;

    // Strobe is gated by q_rdy_i in the same cycle so it can never fire into a busy queue.
    assign w_issue_go = (r_state == S_ISSUE) && bus.q_rdy_i;
    assign w_reject   = r_op ? (r_count == '0)
                             : ((r_count == CW'(CAP)) || (&r_key));
    assign w_tmo_hit  = (r_tmo >= TW'(TO - 1));

    assign bus.q_enq_o     = w_issue_go && !r_op;
    assign bus.q_deq_o     = w_issue_go &&  r_op;
    assign bus.q_data_o    = r_key;
    assign bus.cmd_ready_o = r_cmd_ready;
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_op_o    = r_rsp_op;
    assign bus.rsp_key_o   = r_rsp_key;
    assign bus.rsp_err_o   = r_rsp_err;
    assign count_o         = r_count;
    assign fault_o         = r_fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_op         <= 1'b0;
            r_key        <= '0;
            r_cmd_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_op     <= 1'b0;
            r_rsp_key    <= '0;
            r_rsp_err    <= 1'b0;
            r_count      <= '0;
            r_fault      <= 1'b0;
            r_tmo        <= '0;
            r_wait_first <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid_i && r_cmd_ready) begin
                        r_op        <= bus.cmd_op_i;
                        r_key       <= bus.cmd_key_i;
                        r_rsp_op    <= bus.cmd_op_i;
                        r_rsp_key   <= bus.cmd_key_i;
                        r_cmd_ready <= 1'b0;
                        r_state     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_reject) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_tmo   <= '0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.q_rdy_i) begin
                        if (!r_op && (r_count != CW'(CAP))) r_count <= r_count + CW'(1);
                        if ( r_op && (r_count != '0))       r_count <= r_count - CW'(1);
                        if (r_op) r_rsp_key <= bus.q_data_i;
                        r_tmo        <= r_tmo + TW'(1);
                        r_wait_first <= 1'b1;
                        r_state      <= S_WAIT;
                    end else if (w_tmo_hit) begin
                        r_fault     <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                S_WAIT: begin
                    // First WAIT cycle: queue has not yet dropped ready for our strobe.
                    r_wait_first <= 1'b0;
                    if (!r_wait_first && bus.q_rdy_i) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_state     <= S_RESP;
                    end else if (w_tmo_hit) begin
                        r_fault     <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        if (r_fault) begin
                            r_state <= S_FAULT;
                        end else begin
                            r_cmd_ready <= 1'b1;
                            r_state     <= S_IDLE;
                        end
                    end
                end
                S_FAULT: r_state <= S_FAULT;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qq_host_ctrl.sv
// Directed bench for qq_host_ctrl with a behavioural min-queue head block (CAP=4, TO=64).
module tb_qq_host_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0] count;
    logic       fault;

    qq_host_ctrl_if #(.W(32)) bus ();

    qq_host_ctrl #(.W(32), .CAP(4), .TO(64)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .count_o(count), .fault_o(fault)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural queue: busy for one cycle after each strobe, head = minimum key.
    logic [31:0] mq[$];
    logic        q_busy;
    logic        force_nrdy;
    logic [31:0] m_min;
    int n_enq = 0, n_deq = 0, n_viol = 0;

    assign bus.q_rdy_i  = !q_busy && !force_nrdy;
    assign bus.q_data_i = m_min;

    function automatic logic [31:0] qmin();
        logic [31:0] m = '1;
        foreach (mq[i]) if (mq[i] < m) m = mq[i];
        return m;
    endfunction

    always @(posedge clk) begin
        int idx;
        if (rst) begin
            mq.delete();
            q_busy <= 1'b0;
            m_min  <= '1;
        end else begin
            if (bus.q_enq_o && bus.q_deq_o) n_viol++;
            if ((bus.q_enq_o || bus.q_deq_o) && !bus.q_rdy_i) n_viol++;
            if (bus.q_enq_o) begin
                n_enq++;
                mq.push_back(bus.q_data_o);
            end
            if (bus.q_deq_o) begin
                n_deq++;
                if (mq.size() > 0) begin
                    idx = 0;
                    for (int i = 1; i < mq.size(); i++) if (mq[i] < mq[idx]) idx = i;
                    mq.delete(idx);
                end
            end
            q_busy <= bus.q_enq_o || bus.q_deq_o;
            m_min  <= qmin();
        end
    end

    task automatic do_cmd(input logic op, input logic [31:0] key,
                          output logic rop, output logic [31:0] rkey,
                          output logic rerr, output bit tmo);
        int n;
        tmo = 1'b0;
        @(negedge clk);
        bus.cmd_valid_i = 1'b1; bus.cmd_op_i = op; bus.cmd_key_i = key; bus.rsp_ready_i = 1'b1;
        n = 0;
        while (!bus.cmd_ready_o && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        n = 0;
        while (!bus.rsp_valid_o && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) tmo = 1'b1;
        rop = bus.rsp_op_o; rkey = bus.rsp_key_o; rerr = bus.rsp_err_o;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready_o); end
        n_checks++; if (bus.rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid_o); end
        n_checks++; if (bus.rsp_err_o !== 1'b0 || bus.rsp_op_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err_op: got %b/%b want 0/0", bus.rsp_err_o, bus.rsp_op_o); end
        n_checks++; if (bus.rsp_key_o !== 32'h0 || bus.q_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_keys: got %h/%h want 0/0", bus.rsp_key_o, bus.q_data_o); end
        n_checks++; if (bus.q_enq_o !== 1'b0 || bus.q_deq_o !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got %b/%b want 0/0", bus.q_enq_o, bus.q_deq_o); end
        n_checks++; if (count !== 3'd0 || fault !== 1'b0) begin n_fail++; $display("FAIL reset_count_fault: got %0d/%b want 0/0", count, fault); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sort();
        logic [31:0] keys[3];
        logic [31:0] exp_deq[3];
        logic [2:0]  exp_cnt[6];
        logic rop, rerr; logic [31:0] rkey; bit tmo;
        keys = '{32'h10, 32'h05, 32'h20};
        exp_deq = '{32'h05, 32'h10, 32'h20};
        exp_cnt = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0};
        for (int i = 0; i < 3; i++) begin
            do_cmd(1'b0, keys[i], rop, rkey, rerr, tmo);
            n_checks++; if (tmo || rerr !== 1'b0 || rop !== 1'b0 || rkey !== keys[i]) begin n_fail++; $display("FAIL sort_enq%0d: got tmo=%0b err=%b op=%b key=%h want 0/0/0/%h", i, tmo, rerr, rop, rkey, keys[i]); end
            n_checks++; if (count !== exp_cnt[i]) begin n_fail++; $display("FAIL sort_enq%0d_count: got %0d want %0d", i, count, exp_cnt[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            do_cmd(1'b1, 32'h0, rop, rkey, rerr, tmo);
            n_checks++; if (tmo || rerr !== 1'b0 || rop !== 1'b1 || rkey !== exp_deq[i]) begin n_fail++; $display("FAIL sort_deq%0d: got tmo=%0b err=%b op=%b key=%h want 0/0/1/%h", i, tmo, rerr, rop, rkey, exp_deq[i]); end
            n_checks++; if (count !== exp_cnt[i+3]) begin n_fail++; $display("FAIL sort_deq%0d_count: got %0d want %0d", i, count, exp_cnt[i+3]); end
        end
    endtask

    task automatic test_reject();
        logic rop, rerr; logic [31:0] rkey; bit tmo;
        int ne, nd;
        ne = n_enq; nd = n_deq;
        do_cmd(1'b1, 32'h0, rop, rkey, rerr, tmo);
        n_checks++; if (tmo || rerr !== 1'b1 || rop !== 1'b1) begin n_fail++; $display("FAIL rej_empty_deq: got tmo=%0b err=%b op=%b want 0/1/1", tmo, rerr, rop); end
        n_checks++; if (count !== 3'd0 || n_deq != nd) begin n_fail++; $display("FAIL rej_empty_side: got count=%0d deq_strobes=%0d want 0/%0d", count, n_deq, nd); end
        do_cmd(1'b0, 32'hFFFF_FFFF, rop, rkey, rerr, tmo);
        n_checks++; if (tmo || rerr !== 1'b1 || rkey !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rej_maxkey: got tmo=%0b err=%b key=%h want 0/1/ffffffff", tmo, rerr, rkey); end
        n_checks++; if (count !== 3'd0 || n_enq != ne) begin n_fail++; $display("FAIL rej_maxkey_side: got count=%0d enq_strobes=%0d want 0/%0d", count, n_enq, ne); end
    endtask

    task automatic test_capacity();
        logic [31:0] keys[5];
        logic [31:0] exp_deq[4];
        logic rop, rerr; logic [31:0] rkey; bit tmo;
        int ne;
        keys = '{32'h9, 32'h3, 32'h7, 32'h1, 32'h4};
        exp_deq = '{32'h1, 32'h3, 32'h7, 32'h9};
        ne = n_enq;
        for (int i = 0; i < 5; i++) begin
            do_cmd(1'b0, keys[i], rop, rkey, rerr, tmo);
            n_checks++; if (tmo || rerr !== (i == 4)) begin n_fail++; $display("FAIL cap_enq%0d_err: got tmo=%0b err=%b want 0/%0b", i, tmo, rerr, (i == 4)); end
        end
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL cap_count: got %0d want 4", count); end
        n_checks++; if (n_enq - ne != 4) begin n_fail++; $display("FAIL cap_strobes: got %0d want 4", n_enq - ne); end
        for (int i = 0; i < 4; i++) begin
            do_cmd(1'b1, 32'h0, rop, rkey, rerr, tmo);
            n_checks++; if (tmo || rerr !== 1'b0 || rkey !== exp_deq[i]) begin n_fail++; $display("FAIL cap_deq%0d: got tmo=%0b err=%b key=%h want 0/0/%h", i, tmo, rerr, rkey, exp_deq[i]); end
        end
    endtask

    task automatic test_latency();
        logic rop, rerr; logic [31:0] rkey; bit tmo;
        int k;
        @(negedge clk);
        bus.cmd_valid_i = 1'b1; bus.cmd_op_i = 1'b0; bus.cmd_key_i = 32'h42; bus.rsp_ready_i = 1'b1;
        n_checks++; if (bus.cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL lat_ready: got %b want 1", bus.cmd_ready_o); end
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        k = 1;
        while (!bus.rsp_valid_o && k < 20) begin @(negedge clk); k++; end
        n_checks++; if (k - 1 != 4) begin n_fail++; $display("FAIL lat_edges: got %0d want 4", k - 1); end
        n_checks++; if (bus.cmd_ready_o !== 1'b0 || bus.rsp_err_o !== 1'b0 || bus.rsp_key_o !== 32'h42) begin n_fail++; $display("FAIL lat_rsp: got rdy=%b err=%b key=%h want 0/0/42", bus.cmd_ready_o, bus.rsp_err_o, bus.rsp_key_o); end
        @(negedge clk);
        n_checks++; if (bus.rsp_valid_o !== 1'b0 || bus.cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL lat_same_cycle_hs: got valid=%b rdy=%b want 0/1", bus.rsp_valid_o, bus.cmd_ready_o); end
        do_cmd(1'b1, 32'h0, rop, rkey, rerr, tmo);
        n_checks++; if (tmo || rkey !== 32'h42 || count !== 3'd0) begin n_fail++; $display("FAIL lat_drain: got tmo=%0b key=%h count=%0d want 0/42/0", tmo, rkey, count); end
    endtask

    task automatic test_hold_rsp();
        logic rop, rerr; logic [31:0] rkey; bit tmo;
        int n;
        @(negedge clk);
        bus.cmd_valid_i = 1'b1; bus.cmd_op_i = 1'b0; bus.cmd_key_i = 32'h77; bus.rsp_ready_i = 1'b0;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        n = 0;
        while (!bus.rsp_valid_o && n < 50) begin @(negedge clk); n++; end
        n_checks++; if (n >= 50) begin n_fail++; $display("FAIL hold_wait_rsp: got no response want response"); end
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_key_o !== 32'h77 || bus.cmd_ready_o !== 1'b0) begin n_fail++; $display("FAIL hold_cyc%0d: got valid=%b key=%h rdy=%b want 1/77/0", i, bus.rsp_valid_o, bus.rsp_key_o, bus.cmd_ready_o); end
            @(negedge clk);
        end
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL hold_release: got valid=%b want 0", bus.rsp_valid_o); end
        do_cmd(1'b1, 32'h0, rop, rkey, rerr, tmo);
        n_checks++; if (tmo || rkey !== 32'h77 || rerr !== 1'b0) begin n_fail++; $display("FAIL hold_drain: got tmo=%0b key=%h err=%b want 0/77/0", tmo, rkey, rerr); end
    endtask

    task automatic test_reset_in_wait();
        int n, s;
        bit saw_rsp;
        @(negedge clk);
        bus.cmd_valid_i = 1'b1; bus.cmd_op_i = 1'b0; bus.cmd_key_i = 32'h33; bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        n = 0;
        while (!bus.q_enq_o && n < 20) begin @(negedge clk); n++; end
        n_checks++; if (n >= 20) begin n_fail++; $display("FAIL rw_strobe_seen: got none want q_enq_o"); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.rsp_valid_o !== 1'b0 || bus.rsp_err_o !== 1'b0 || bus.rsp_op_o !== 1'b0) begin n_fail++; $display("FAIL rw_rsp_flags: got %b/%b/%b want 0/0/0", bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_op_o); end
        n_checks++; if (bus.rsp_key_o !== 32'h0 || bus.q_data_o !== 32'h0) begin n_fail++; $display("FAIL rw_keys: got %h/%h want 0/0", bus.rsp_key_o, bus.q_data_o); end
        n_checks++; if (count !== 3'd0 || fault !== 1'b0 || bus.cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL rw_state: got count=%0d fault=%b rdy=%b want 0/0/1", count, fault, bus.cmd_ready_o); end
        rst = 1'b0;
        s = n_enq + n_deq;
        saw_rsp = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.rsp_valid_o) saw_rsp = 1'b1;
        end
        n_checks++; if (n_enq + n_deq != s || saw_rsp) begin n_fail++; $display("FAIL rw_after: got strobes=%0d rsp=%0b want %0d/0", n_enq + n_deq, saw_rsp, s); end
    endtask

    task automatic test_timeout();
        int k, ne;
        bit bad;
        ne = n_enq;
        force_nrdy = 1'b1;
        @(negedge clk);
        bus.cmd_valid_i = 1'b1; bus.cmd_op_i = 1'b0; bus.cmd_key_i = 32'h11; bus.rsp_ready_i = 1'b0;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        k = 1;
        while (!bus.rsp_valid_o && k < 200) begin @(negedge clk); k++; end
        n_checks++; if (k != 66) begin n_fail++; $display("FAIL to_latency: got %0d want 66", k); end
        n_checks++; if (fault !== 1'b1 || bus.rsp_err_o !== 1'b1 || bus.rsp_op_o !== 1'b0) begin n_fail++; $display("FAIL to_rsp: got fault=%b err=%b op=%b want 1/1/0", fault, bus.rsp_err_o, bus.rsp_op_o); end
        n_checks++; if (n_enq != ne || count !== 3'd0 || bus.cmd_ready_o !== 1'b0) begin n_fail++; $display("FAIL to_side: got strobes=%0d count=%0d rdy=%b want %0d/0/0", n_enq, count, bus.cmd_ready_o, ne); end
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.rsp_valid_o !== 1'b0 || fault !== 1'b1) begin n_fail++; $display("FAIL to_retire: got valid=%b fault=%b want 0/1", bus.rsp_valid_o, fault); end
        force_nrdy = 1'b0;
        bus.cmd_valid_i = 1'b1;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.cmd_ready_o !== 1'b0 || bus.rsp_valid_o !== 1'b0 || fault !== 1'b1) bad = 1'b1;
        end
        n_checks++; if (bad) begin n_fail++; $display("FAIL to_sticky: got ready/response/fault change want held fault"); end
        bus.cmd_valid_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (fault !== 1'b0 || bus.cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL to_reset_clears: got fault=%b rdy=%b want 0/1", fault, bus.cmd_ready_o); end
    endtask

    initial begin
        rst = 1'b1;
        force_nrdy = 1'b0;
        bus.cmd_valid_i = 1'b0; bus.cmd_op_i = 1'b0; bus.cmd_key_i = '0; bus.rsp_ready_i = 1'b0;
        test_reset();
        test_sort();
        test_reject();
        test_capacity();
        test_latency();
        test_hold_rsp();
        test_reset_in_wait();
        test_timeout();
        n_checks++; if (n_viol != 0) begin n_fail++; $display("FAIL strobe_rules: got %0d violations want 0", n_viol); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule
